// File: rtl/lector_teclado_pkg.sv
// Shared calculator definitions: key codes, keypad FSM encoding and the keypad
// map helpers used by the row-scanning reader.
package lector_teclado_pkg;

  typedef enum logic [2:0] {
    ESCANEAR       = 3'd0,
    DEB_PRESION    = 3'd1,
    EMITIR         = 3'd2,
    ESPERAR_SOLTAR = 3'd3,
    DEB_SOLTAR     = 3'd4
  } estado_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] OP_SUMA    = KEY_A;
  localparam logic [3:0] OP_RESTA   = KEY_B;
  localparam logic [3:0] OP_MULT    = KEY_C;
  localparam logic [3:0] OP_DIV     = KEY_D;
  localparam logic [3:0] KEY_BORRAR = KEY_E;
  localparam logic [3:0] KEY_IGUAL  = KEY_F;

  localparam logic [3:0] COLS_IDLE = 4'b1111;

  // Active-low row drive pattern for a row index.
  function automatic logic [3:0] fila_activa(input logic [1:0] fila);
    logic [3:0] patron;
    case (fila)
      2'd0:    patron = 4'b1110;
      2'd1:    patron = 4'b1101;
      2'd2:    patron = 4'b1011;
      2'd3:    patron = 4'b0111;
      default: patron = 4'b1110;
    endcase
    return patron;
  endfunction

  // Lowest-index low column wins when several keys share a row.
  function automatic logic [1:0] columna_baja(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0])      idx = 2'd0;
    else if (!cols[1]) idx = 2'd1;
    else if (!cols[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
    logic [3:0] codigo;
    case ({fila, col})
      4'b00_00: codigo = KEY_1;
      4'b00_01: codigo = KEY_2;
      4'b00_10: codigo = KEY_3;
      4'b00_11: codigo = OP_SUMA;
      4'b01_00: codigo = KEY_4;
      4'b01_01: codigo = KEY_5;
      4'b01_10: codigo = KEY_6;
      4'b01_11: codigo = OP_RESTA;
      4'b10_00: codigo = KEY_7;
      4'b10_01: codigo = KEY_8;
      4'b10_10: codigo = KEY_9;
      4'b10_11: codigo = OP_MULT;
      4'b11_00: codigo = KEY_BORRAR;
      4'b11_01: codigo = KEY_0;
      4'b11_10: codigo = KEY_IGUAL;
      4'b11_11: codigo = OP_DIV;
      default:  codigo = KEY_0;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones so
// idle pulled-up lines never look active.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Synchronizer flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/lector_teclado.sv
// 4x4 keypad reader: scans rows, debounces press and release, and emits one
// classified strobe per confirmed key press.
module lector_teclado
  import lector_teclado_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_TICKS = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       numero_en,
  output logic       operacion_en,
  output logic       igual_tecla_en,
  output logic       borrar_en
);

  localparam int SLOT_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam int DEB_W  = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX  = {SLOT_W{1'b1}};
  localparam logic [DEB_W-1:0]  DEB_MAX   = {DEB_W{1'b1}};

  estado_t           state_r, state_s;
  logic [1:0]        row_r, row_s;
  logic [SLOT_W-1:0] slot_r, slot_s;
  logic [DEB_W-1:0]  deb_r, deb_s;
  logic [3:0]        patron_r, patron_s;
  logic [3:0]        cols_s;
  logic [3:0]        codigo_s;
  logic              emitir_s;
  logic              idle_s;

  logic [3:0] filas_r;
  logic [3:0] tecla_r;
  logic       tecla_valida_r;
  logic       numero_r;
  logic       operacion_r;
  logic       igual_r;
  logic       borrar_r;

  sincronizador_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (columnas),
    .q     (cols_s)
  );

  assign idle_s   = (cols_s == COLS_IDLE);
  assign codigo_s = codigo_tecla(row_r, columna_baja(patron_r));

  // Next-state logic for scan, debounce and release tracking.
  always_comb begin
    state_s  = state_r;
    row_s    = row_r;
    slot_s   = slot_r;
    deb_s    = deb_r;
    patron_s = patron_r;
    emitir_s = 1'b0;
    case (state_r)
      ESCANEAR: begin
        if (slot_r == SLOT_LAST) begin
          slot_s = {SLOT_W{1'b0}};
          if (idle_s) begin
            row_s = row_r + 2'd1;
          end else begin
            state_s  = DEB_PRESION;
            patron_s = cols_s;
            deb_s    = {DEB_W{1'b0}};
          end
        end else begin
          slot_s = (slot_r == SLOT_MAX) ? slot_r : slot_r + SLOT_W'(1);
        end
      end
      DEB_PRESION: begin
        if (idle_s) begin
          state_s = ESCANEAR;
          slot_s  = {SLOT_W{1'b0}};
          deb_s   = {DEB_W{1'b0}};
        end else if (cols_s != patron_r) begin
          patron_s = cols_s;
          deb_s    = {DEB_W{1'b0}};
        end else if (deb_r == DEB_LAST) begin
          state_s  = EMITIR;
          emitir_s = 1'b1;
        end else begin
          deb_s = (deb_r == DEB_MAX) ? deb_r : deb_r + DEB_W'(1);
        end
      end
      EMITIR: begin
        state_s = ESPERAR_SOLTAR;
        deb_s   = {DEB_W{1'b0}};
      end
      ESPERAR_SOLTAR: begin
        if (idle_s) begin
          state_s = DEB_SOLTAR;
          deb_s   = {DEB_W{1'b0}};
        end else begin
          state_s = ESPERAR_SOLTAR;
        end
      end
      DEB_SOLTAR: begin
        if (!idle_s) begin
          state_s = ESPERAR_SOLTAR;
          deb_s   = {DEB_W{1'b0}};
        end else if (deb_r == DEB_LAST) begin
          state_s = ESCANEAR;
          row_s   = row_r + 2'd1;
          slot_s  = {SLOT_W{1'b0}};
          deb_s   = {DEB_W{1'b0}};
        end else begin
          deb_s = (deb_r == DEB_MAX) ? deb_r : deb_r + DEB_W'(1);
        end
      end
      default: begin
        state_s = ESCANEAR;
        slot_s  = {SLOT_W{1'b0}};
        deb_s   = {DEB_W{1'b0}};
      end
    endcase
  end

  // FSM state, row and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ESCANEAR;
      row_r    <= 2'd0;
      slot_r   <= {SLOT_W{1'b0}};
      deb_r    <= {DEB_W{1'b0}};
      patron_r <= COLS_IDLE;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      slot_r   <= slot_s;
      deb_r    <= deb_s;
      patron_r <= patron_s;
    end
  end

  // Registered row drive, key code and strobes; strobes are high exactly
  // during the EMITIR cycle because they load on the transition into it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filas_r        <= 4'b1110;
      tecla_r        <= KEY_0;
      tecla_valida_r <= 1'b0;
      numero_r       <= 1'b0;
      operacion_r    <= 1'b0;
      igual_r        <= 1'b0;
      borrar_r       <= 1'b0;
    end else begin
      filas_r        <= fila_activa(row_s);
      tecla_valida_r <= emitir_s;
      numero_r       <= emitir_s && (codigo_s <= KEY_9);
      operacion_r    <= emitir_s && (codigo_s >= OP_SUMA) && (codigo_s <= OP_DIV);
      igual_r        <= emitir_s && (codigo_s == KEY_IGUAL);
      borrar_r       <= emitir_s && (codigo_s == KEY_BORRAR);
      if (emitir_s) begin
        tecla_r <= codigo_s;
      end else begin
        tecla_r <= tecla_r;
      end
    end
  end

  assign filas          = filas_r;
  assign tecla          = tecla_r;
  assign tecla_valida   = tecla_valida_r;
  assign numero_en      = numero_r;
  assign operacion_en   = operacion_r;
  assign igual_tecla_en = igual_r;
  assign borrar_en      = borrar_r;

endmodule

// File: tb/tb_lector_teclado.sv
// Scoreboard bench for lector_teclado: a keypad model drives columns, expected
// key codes are queued at press time and compared on every tecla_valida pulse.
module tb_lector_teclado;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] tecla;
  logic       tecla_valida, numero_en, operacion_en, igual_tecla_en, borrar_en;

  lector_teclado #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .columnas       (columnas),
    .filas          (filas),
    .tecla          (tecla),
    .tecla_valida   (tecla_valida),
    .numero_en      (numero_en),
    .operacion_en   (operacion_en),
    .igual_tecla_en (igual_tecla_en),
    .borrar_en      (borrar_en)
  );

  always #5 clk = ~clk;

  // Keypad model: the pressed key pulls its columns low only while its row is driven.
  logic       key_on = 1'b0;
  int         key_row = 0;
  logic [3:0] key_cols = 4'b0000;
  always_comb columnas = (key_on && (filas[key_row] == 1'b0)) ? ~key_cols : 4'b1111;

  int         checks_cnt = 0;
  int         errors_cnt = 0;
  logic [3:0] exp_q[$];
  int         pulse_cnt = 0;
  int         cycle = 0;
  int         last_pulse_cycle = 0;
  logic       prev_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: pop the scoreboard on each pulse and check class strobes.
  always @(negedge clk) begin
    logic [4:0] exp_code;
    if (!reset) begin
      if (tecla_valida) begin
        pulse_cnt++;
        last_pulse_cycle = cycle;
        check_val("pulse_width", prev_valid, 1'b0);
        exp_code = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 5'h10;
        check_val("tecla", {27'd0, 1'b0, tecla}, {27'd0, exp_code});
        check_val("numero_en", numero_en, exp_code <= 5'd9);
        check_val("operacion_en", operacion_en, (exp_code >= 5'd10) && (exp_code <= 5'd13));
        check_val("borrar_en", borrar_en, exp_code == 5'd14);
        check_val("igual_tecla_en", igual_tecla_en, exp_code == 5'd15);
      end else begin
        check_val("idle_strobes", {numero_en, operacion_en, igual_tecla_en, borrar_en}, 4'b0000);
      end
      prev_valid = tecla_valida;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int r, input logic [3:0] c, input logic [3:0] code);
    key_row  = r;
    key_cols = c;
    key_on   = 1'b1;
    exp_q.push_back(code);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    cycles(1);
    check_val(tag, pulse_cnt, target);
  endtask

  task automatic wait_filas(input logic [3:0] v, input int budget, input string tag);
    int n = 0;
    while (filas !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, filas, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stable_start;
    cycles(3);
    check_val("rst_filas", filas, 4'b1110);
    check_val("rst_tecla", tecla, 4'h0);
    check_val("rst_strobes", {tecla_valida, numero_en, operacion_en, igual_tecla_en, borrar_en}, 5'b0);
    reset = 1'b0;
    wait_filas(4'b1101, 20, "scan_row1");

    // Held '5': one pulse, none while held, a second only after release and re-press.
    press(1, 4'b0010, 4'h5);
    wait_pulses(1, 200, "t1_first_pulse");
    cycles(100);
    check_val("t1_hold_no_repeat", pulse_cnt, 1);
    key_on = 1'b0;
    wait_filas(4'b1011, 60, "t1_resume");
    press(1, 4'b0010, 4'h5);
    wait_pulses(2, 200, "t1_second_pulse");
    key_on = 1'b0;
    cycles(40);

    // Contact bounce on press, then stable hold.
    key_row = 1; key_cols = 4'b0010; key_on = 1'b1;
    exp_q.push_back(4'h5);
    for (int i = 0; i < 10; i++) begin
      cycles(3);
      key_on = ~key_on;
    end
    key_on = 1'b1;
    stable_start = cycle;
    wait_pulses(3, 200, "t2_pulse");
    check_val("t2_stable_delay", ((last_pulse_cycle - stable_start) >= 10) ? 1 : 0, 1);
    key_on = 1'b0;
    cycles(40);

    // '#', 'A', '*' sequence.
    press(3, 4'b0100, 4'hF);
    wait_pulses(4, 200, "t3_igual");
    key_on = 1'b0; cycles(40);
    press(0, 4'b1000, 4'hA);
    wait_pulses(5, 200, "t3_suma");
    key_on = 1'b0; cycles(40);
    press(3, 4'b0001, 4'hE);
    wait_pulses(6, 200, "t3_borrar");
    key_on = 1'b0; cycles(40);

    // Two columns low on row2: lowest column (7) wins.
    press(2, 4'b0101, 4'h7);
    wait_pulses(7, 200, "t4_multi");
    key_on = 1'b0; cycles(40);

    // Release bounce inside release debounce.
    press(1, 4'b0010, 4'h5);
    wait_pulses(8, 200, "t5_pulse");
    cycles(5);
    key_on = 1'b0;
    cycles(5);
    key_on = 1'b1;
    cycles(2);
    key_on = 1'b0;
    cycles(9);
    check_val("t5_hold_row", filas, 4'b1101);
    wait_filas(4'b1011, 40, "t5_resume");
    check_val("t5_no_extra", pulse_cnt, 8);

    // Reset in the middle of the press debounce with the key still held.
    wait_filas(4'b1110, 40, "t6_row0");
    press(1, 4'b0010, 4'h5);
    wait_filas(4'b1101, 20, "t6_row1");
    cycles(9);
    reset = 1'b1;
    cycles(1);
    check_val("t6_rst_filas", filas, 4'b1110);
    check_val("t6_rst_tecla", tecla, 4'h0);
    check_val("t6_rst_strobes", {tecla_valida, numero_en, operacion_en, igual_tecla_en, borrar_en}, 5'b0);
    cycles(1);
    reset = 1'b0;
    wait_pulses(9, 200, "t6_redebounce");
    key_on = 1'b0;
    cycles(40);

    check_val("queue_empty", exp_q.size(), 0);
    check_val("total_pulses", pulse_cnt, 9);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/lector_teclado.md
LECTOR_TECLADO -- requirements
Module: lector_teclado

Interface
REQ-001 The block SHALL have parameter SCAN_TICKS, default 1000, giving clk cycles per row slot (legal minimum 4).
REQ-002 The block SHALL have parameter DEBOUNCE_TICKS, default 20000, giving the number of consecutive stable clk cycles that confirm a press or a release.
REQ-003 The block SHALL have port clk  input  1  as the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset  input  1  as a synchronous, active-high reset.
REQ-005 The block SHALL have port columnas  input  4  carrying keypad columns, active-low, pulled up, asynchronous to clk.
REQ-006 The block SHALL have port filas  output  4  driving keypad rows, active-low, with exactly one row low at a time.
REQ-007 The block SHALL have port tecla  output  4  holding the code of the last confirmed key.
REQ-008 The block SHALL have port tecla_valida  output  1  as a one-cycle pulse per confirmed press.
REQ-009 The block SHALL have port numero_en  output  1  pulsing with tecla_valida when tecla is 0x0-0x9.
REQ-010 The block SHALL have port operacion_en  output  1  pulsing with tecla_valida when tecla is 0xA-0xD.
REQ-011 The block SHALL have port igual_tecla_en  output  1  pulsing with tecla_valida when tecla is 0xF.
REQ-012 The block SHALL have port borrar_en  output  1  pulsing with tecla_valida when tecla is 0xE.

Function
REQ-013 Key map SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = *,0,#,D. Codes are digit value, A=0xA (+), B=0xB (-), C=0xC (*), D=0xD (/), *=0xE, #=0xF.
REQ-014 columnas SHALL pass through a 2-flop synchronizer before any use; all column decisions use the synchronized value.
REQ-015 The FSM SHALL have states ESCANEAR, DEB_PRESION, EMITIR, ESPERAR_SOLTAR and DEB_SOLTAR.
REQ-016 In ESCANEAR, each row SHALL be driven for SCAN_TICKS cycles, and columns SHALL be evaluated only on the last cycle of the slot.
REQ-017 If no column is low at that evaluation, the row SHALL advance (0->1->2->3->0 wrap).
REQ-018 If any column is low at that evaluation, the FSM SHALL go to DEB_PRESION, hold the current row, latch the column pattern, and clear the debounce counter.
REQ-019 In DEB_PRESION, the counter SHALL increment while the pattern equals the latched pattern.
REQ-020 In DEB_PRESION, a different non-idle pattern SHALL be re-latched and the counter cleared.
REQ-021 In DEB_PRESION, an all-high pattern SHALL return the FSM to ESCANEAR on the same row with the slot counter cleared, and no pulse is emitted.
REQ-022 When the counter reaches DEBOUNCE_TICKS-1 with a stable pattern, the FSM SHALL enter EMITIR.
REQ-023 If several columns are low, the lowest-index low column SHALL select the key.
REQ-024 EMITIR SHALL last exactly one cycle: tecla is updated and tecla_valida plus exactly one class strobe are high in that cycle only.
REQ-025 After EMITIR, the FSM SHALL enter ESPERAR_SOLTAR, holding the row until all columns are high.
REQ-026 From ESPERAR_SOLTAR, the FSM SHALL enter DEB_SOLTAR, where DEBOUNCE_TICKS consecutive all-high cycles return it to ESCANEAR (next row).
REQ-027 Any low column during DEB_SOLTAR SHALL return the FSM to ESPERAR_SOLTAR; a held key never produces a second pulse.
REQ-028 Counters SHALL be sized by $clog2 of their parameter and saturate, never wrapping.
REQ-029 tecla SHALL hold its value between presses.
REQ-030 All strobes SHALL be registered outputs.

Reset
REQ-031 On reset the block SHALL set: state ESCANEAR, row 0 (filas = 4'b1110), counters 0, synchronizer flops 4'b1111, tecla = 0x0, all strobes 0.
REQ-032 Reset asserted mid-debounce or while a key is held SHALL abort the operation with no pulse; a key still held after reset is detected afresh through the full debounce.

Structure
REQ-033 The key-code constants (KEY_0..KEY_F, OP_SUMA, OP_RESTA, OP_MULT, OP_DIV, KEY_BORRAR, KEY_IGUAL) and the FSM state encoding SHALL live in the shared calculator package.
REQ-034 The synchronizer SHALL be the sub-module sincronizador_2ff, parameterized by width.

Verification (SCAN_TICKS=4, DEBOUNCE_TICKS=8)
REQ-035 Test: hold key '5' (row1, col1) -> exactly one tecla_valida with tecla=0x5 and numero_en=1, no pulse during the hold, another pulse only after release and a new press.
REQ-036 Test: toggle col1 every 3 cycles during the press, then hold stable -> single pulse, only after 8 stable cycles.
REQ-037 Test: press '#', then 'A', then '*' -> igual_tecla_en, operacion_en (tecla=0xA) and borrar_en each pulse once, with no other strobe high.
REQ-038 Test: hold cols 0 and 2 low on row2 -> tecla=0x7.
REQ-039 Test: bounce on release (low for 2 cycles within DEB_SOLTAR) -> no extra pulse, and scanning resumes only after 8 clean high cycles.
REQ-040 Test: assert reset at debounce count 5 -> all outputs at reset values, and the still-held key is pulsed once after a full re-debounce.
